// File: rtl/vout_pkg.sv
// Shared types and default 640x480@60 timing for the video output path.
// Provides pixel_t ({R,G,B} RGB444), counter type and a counter cast helper.
package vout_pkg;

  localparam int CNT_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic cnt_t to_cnt(input int v);
    return cnt_t'(v);
  endfunction

endpackage

// File: rtl/stream_out_if.sv
// Pixel FIFO read port: rd pops, data valid the cycle after rd, empty flag.
// master = stream_out (consumer), slave = frame-buffer read FIFO.
interface stream_out_if;
  import vout_pkg::*;

  logic   rd;
  pixel_t data;
  logic   empty;

  modport master (
    output rd,
    input  data,
    input  empty
  );

  modport slave (
    input  rd,
    output data,
    output empty
  );

endinterface

// File: rtl/vout_timing.sv
// Free-running h/v counters with region decode (active, raw HS/VS),
// frame-start pulse and next-line prefetch request (o_line_req/o_line).
module vout_timing
  import vout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       i_pxl_clk,
  input  logic       i_reset,
  output logic       o_act,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_frame_start,
  output logic       o_line_req,
  output logic [8:0] o_line
);

  localparam cnt_t H_ACT = to_cnt(H_ACTIVE);
  localparam cnt_t H_SB  = to_cnt(H_ACTIVE + H_FP);
  localparam cnt_t H_SE  = to_cnt(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_END =
    to_cnt(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_ACT = to_cnt(V_ACTIVE);
  localparam cnt_t V_LA  = to_cnt(V_ACTIVE - 1);
  localparam cnt_t V_SB  = to_cnt(V_ACTIVE + V_FP);
  localparam cnt_t V_SE  = to_cnt(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_END =
    to_cnt(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_wrap;
  logic last_line;
  logic [8:0] nxt_line;

  assign h_wrap    = (h_cnt == H_END);
  assign last_line = (v_cnt == V_END);

  always_ff @(posedge i_pxl_clk) begin
    if (i_reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + cnt_t'(1);
      if (h_wrap)
        v_cnt <= last_line ? '0 : v_cnt + cnt_t'(1);
    end
  end

  assign o_act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign o_hs  = (h_cnt >= H_SB) && (h_cnt < H_SE);
  assign o_vs  = (v_cnt >= V_SB) && (v_cnt < V_SE);

  // Counters sit at 0 while reset is held; gate so the pulse
  // only appears once the counters are free to run.
  assign o_frame_start =
    (h_cnt == '0) && (v_cnt == '0) && !i_reset;

  // Request the line that follows, one line ahead of display;
  // the last blanking line prefetches line 0.
  assign nxt_line =
    last_line ? 9'd0 : 9'(v_cnt + cnt_t'(1));
  assign o_line_req =
    (h_cnt == H_ACT) && ((v_cnt < V_LA) || last_line);
  assign o_line = o_line_req ? nxt_line : 9'd0;

endmodule

// File: rtl/stream_out.sv
// Video output generator: pops RGB444 pixels from the read FIFO during the
// active window and drives RGB/HS/VS/DE through a 2-stage pipeline.
// Ports: i_pxl_clk, i_reset (sync, high), i_enable, i_clr_underflow,
// fifo (FIFO read port), o_frame_start, o_line_req/o_line, o_R/G/B,
// o_HS/o_VS, o_de, o_underflow (sticky).
module stream_out
  import vout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_NEG   = 1,
  parameter int VS_NEG   = 1
) (
  input  logic         i_pxl_clk,
  input  logic         i_reset,
  input  logic         i_enable,
  input  logic         i_clr_underflow,
  stream_out_if.master fifo,
  output logic         o_frame_start,
  output logic         o_line_req,
  output logic [8:0]   o_line,
  output logic [3:0]   o_R,
  output logic [3:0]   o_G,
  output logic [3:0]   o_B,
  output logic         o_HS,
  output logic         o_VS,
  output logic         o_de,
  output logic         o_underflow
);

  localparam logic HS_POL = (HS_NEG != 0);
  localparam logic VS_POL = (VS_NEG != 0);

  logic act;
  logic hs_raw;
  logic vs_raw;
  logic fs;

  vout_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_pxl_clk     (i_pxl_clk),
    .i_reset       (i_reset),
    .o_act         (act),
    .o_hs          (hs_raw),
    .o_vs          (vs_raw),
    .o_frame_start (fs),
    .o_line_req    (o_line_req),
    .o_line        (o_line)
  );

  assign o_frame_start = fs;

  logic r_run;
  logic run_now;
  logic want;
  logic uf_now;

  // The enable decision for a new frame already governs its
  // first pixel, so bypass the latch on the frame-start cycle.
  assign run_now = fs ? i_enable : r_run;
  assign want    = act & run_now;
  assign fifo.rd = want & ~fifo.empty;
  assign uf_now  = want & fifo.empty;

  logic s1_de;
  logic s1_hs;
  logic s1_vs;
  logic s1_rd;
  logic s1_uf;
  pixel_t px;

  always_ff @(posedge i_pxl_clk) begin
    if (i_reset) begin
      r_run <= 1'b0;
      s1_de <= 1'b0;
      s1_hs <= HS_POL;
      s1_vs <= VS_POL;
      s1_rd <= 1'b0;
      s1_uf <= 1'b0;
    end else begin
      if (fs)
        r_run <= i_enable;
      s1_de <= want;
      s1_hs <= hs_raw ^ HS_POL;
      s1_vs <= vs_raw ^ VS_POL;
      s1_rd <= fifo.rd;
      s1_uf <= uf_now;
    end
  end

  // FIFO data lands alongside stage 1; a starved pixel is black.
  always_ff @(posedge i_pxl_clk) begin
    if (i_reset) begin
      px   <= '0;
      o_de <= 1'b0;
      o_HS <= HS_POL;
      o_VS <= VS_POL;
    end else begin
      px   <= s1_rd ? fifo.data : '0;
      o_de <= s1_de;
      o_HS <= s1_hs;
      o_VS <= s1_vs;
    end
  end

  assign o_R = px.r;
  assign o_G = px.g;
  assign o_B = px.b;

  always_ff @(posedge i_pxl_clk) begin
    if (i_reset)
      o_underflow <= 1'b0;
    else if (s1_uf)
      o_underflow <= 1'b1;
    else if (i_clr_underflow)
      o_underflow <= 1'b0;
  end

endmodule

// File: tb/tb_stream_out.sv
// Self-checking bench for stream_out on a reduced 16x8 raster.
// Scoreboard of expected pins per counter cycle, popped 2 cycles later.
module tb_stream_out;
  import vout_pkg::*;

  localparam int HA  = 16;
  localparam int HF  = 2;
  localparam int HSY = 4;
  localparam int HB  = 3;
  localparam int HT  = HA + HF + HSY + HB;
  localparam int VA  = 8;
  localparam int VF  = 1;
  localparam int VSY = 2;
  localparam int VB  = 2;
  localparam int VT  = VA + VF + VSY + VB;
  localparam int FT  = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic fs, lreq, hs, vs, de, uf;
  logic [8:0] line;
  logic [3:0] r, g, b;

  stream_out_if fifo ();

  stream_out #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
    .HS_NEG (1), .VS_NEG (1)
  ) dut (
    .i_pxl_clk       (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_clr_underflow (clr),
    .fifo            (fifo),
    .o_frame_start   (fs),
    .o_line_req      (lreq),
    .o_line          (line),
    .o_R             (r),
    .o_G             (g),
    .o_B             (b),
    .o_HS            (hs),
    .o_VS            (vs),
    .o_de            (de),
    .o_underflow     (uf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  // FIFO model: 1-cycle read latency.
  logic [11:0] fq[$];
  int   q_n      = 0;
  logic fill_req = 1'b0;
  logic fe_force = 1'b0;

  assign fifo.empty = fe_force || (q_n == 0);

  always @(posedge clk) begin
    if (fill_req)
      for (int i = 0; i < 400; i++)
        fq.push_back(12'(i));
    if (fifo.rd && fq.size() > 0) begin
      fifo.data <= fq[0];
      void'(fq.pop_front());
    end
    q_n <= fq.size();
  end

  // Scoreboard model
  logic rst_q = 1'b1;
  always @(posedge clk) rst_q <= rst;

  localparam logic [14:0] RST_E = {1'b0, 1'b1, 1'b1, 12'h0};

  logic [14:0] exp_q[$];
  int mh = 0;
  int mv = 0;
  bit mrun = 1'b0;

  always @(negedge clk) begin
    logic [14:0] e;
    bit mfs, mre, mact, mrd, mhs, mvs, mlr;
    logic [8:0] mline;
    logic [11:0] mpix;
    if (rst_q && rst) begin
      exp_q.delete();
      exp_q.push_back(RST_E);
      exp_q.push_back(RST_E);
      mh = 0;
      mv = 0;
      mrun = 1'b0;
      check("reset",
        {de, hs, vs, r, g, b, fifo.rd, fs, lreq, line, uf},
        {1'b0, 1'b1, 1'b1, 12'h0, 1'b0, 1'b0, 1'b0,
         9'h0, 1'b0});
    end else begin
      mfs  = (mh == 0) && (mv == 0) && !rst;
      mre  = mfs ? en : mrun;
      mact = (mh < HA) && (mv < VA);
      mrd  = mact && mre && !fifo.empty;
      mpix = mrd ? fq[0] : 12'h0;
      mhs  = !((mh >= HA + HF) && (mh < HA + HF + HSY));
      mvs  = !((mv >= VA + VF) && (mv < VA + VF + VSY));
      mlr  = (mh == HA) && ((mv < VA - 1) || (mv == VT - 1));
      mline = (!mlr || mv == VT - 1) ? 9'd0 : 9'(mv + 1);
      check("ctr", {fifo.rd, fs, lreq, line},
                   {mrd, mfs, mlr, mline});
      exp_q.push_back({mact && mre, mhs, mvs, mpix});
      if (exp_q.size() > 2) begin
        e = exp_q.pop_front();
        check("pix", {de, hs, vs, r, g, b}, e);
      end
      if (mfs) mrun = en;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  end

  // Stimulus sequencing
  int cyc = 0;

  task automatic adv(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic smp(input int k);
    adv(k);
    @(negedge clk);
  endtask

  task automatic wait_fs();
    int t = 0;
    @(negedge clk);
    while (!fs && t < 2 * FT) begin
      @(negedge clk);
      t++;
    end
    check("fs_seen", fs, 1);
    cyc = 0;
  endtask

  initial begin
    int hs_lo, vs_lo, de_hi, rd_hi, pops;
    int t;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("fs_rel", fs, 1);
    cyc = 0;

    hs_lo = 0; vs_lo = 0; de_hi = 0; rd_hi = 0;
    for (int i = 2; i < 2 + FT; i++) begin
      smp(i);
      hs_lo += int'(!hs);
      vs_lo += int'(!vs);
      de_hi += int'(de);
      rd_hi += int'(fifo.rd);
    end
    check("hs_lo", hs_lo, HSY * VT);
    check("vs_lo", vs_lo, VSY * HT);
    check("de_off", de_hi, 0);
    check("rd_off", rd_hi, 0);

    adv(cyc + 1);
    fill_req = 1'b1;
    adv(cyc + 1);
    fill_req = 1'b0;
    en = 1'b1;
    wait_fs();

    pops = int'(fifo.rd);
    for (int i = 1; i < HT; i++) begin
      smp(i);
      pops += int'(fifo.rd);
      if (i == 2)
        check("first_px", {de, r, g, b}, {1'b1, 12'h000});
    end
    check("pops_l0", pops, HA);

    t = 5 * HT + 10;
    adv(t);
    fe_force = 1'b1;
    adv(t + 4);
    fe_force = 1'b0;
    smp(t + 6);
    check("px_after_uf", {de, r, g, b},
          {1'b1, 12'(5 * HA + 10)});
    smp(t + 7);
    check("uf_set", uf, 1);
    adv(t + 10);
    clr = 1'b1;
    adv(t + 11);
    clr = 1'b0;
    @(negedge clk);
    check("uf_clr", uf, 0);

    t = 6 * HT + 10;
    adv(t);
    fe_force = 1'b1;
    adv(t + 1);
    fe_force = 1'b0;
    clr = 1'b1;
    adv(t + 2);
    clr = 1'b0;
    smp(t + 3);
    check("uf_set_wins", uf, 1);

    adv(7 * HT + 5);
    en = 1'b0;
    smp(7 * HT + 8);
    check("de_after_drop", de, 1);

    wait_fs();
    de_hi = 0; rd_hi = 0;
    for (int i = 2; i < FT; i++) begin
      smp(i);
      de_hi += int'(de);
      rd_hi += int'(fifo.rd);
    end
    check("de_off2", de_hi, 0);
    check("rd_off2", rd_hi, 0);

    wait_fs();
    t = 5 * HT + 12;
    adv(t);
    rst = 1'b1;
    adv(t + 1);
    @(negedge clk);
    check("rst_vals",
      {de, hs, vs, r, g, b, uf, lreq, line},
      {1'b0, 1'b1, 1'b1, 12'h0, 1'b0, 1'b0, 9'h0});
    adv(t + 2);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    check("fs_after_rst", fs, 1);
    cyc = 0;
    smp(2 * FT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
